// File: rtl/window_gen_3x3.sv
// 3x3 neighbourhood window generator for a raster pixel stream.
// Two line RAMs hold the previous two rows. Per-row column shift registers
// hold the previous two columns. Taps that fall outside the image are either
// zeroed or replicated from the nearest in-image pixel.
module window_gen_3x3 #(
  parameter int DATA_W      = 8,
  parameter int WIDTH       = 640,
  parameter int BORDER_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     pixel_in,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  output logic [9*DATA_W-1:0]   window,
  output logic                  out_valid,
  output logic                  out_interior,
  output logic                  out_hsync,
  output logic                  out_vsync
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [XW-1:0]     x;
  logic [1:0]        y;
  logic [XW-1:0]     xe;
  logic [1:0]        ye;
  logic [DATA_W-1:0] ram_a [WIDTH];
  logic [DATA_W-1:0] ram_b [WIDTH];
  logic [DATA_W-1:0] a_rd;
  logic [DATA_W-1:0] b_rd;
  // sr[r][0] holds column x-1 and sr[r][1] holds column x-2 of row r.
  // Row index 0 is y-2, 1 is y-1, 2 is y.
  logic [DATA_W-1:0] sr   [3][2];
  logic [DATA_W-1:0] grid [3][3];
  logic [9*DATA_W-1:0] window_d;

  // A vsync pulse makes the pixel in the same cycle (0,0) of the new frame.
  assign xe   = vsync ? '0 : x;
  assign ye   = vsync ? '0 : y;
  assign a_rd = ram_a[xe];
  assign b_rd = ram_b[xe];

  // Raw 3x3 grid before border fill: rows y-2..y, columns x-2..x.
  always_comb begin
    grid[0][0] = sr[0][1];
    grid[0][1] = sr[0][0];
    grid[0][2] = b_rd;
    grid[1][0] = sr[1][1];
    grid[1][1] = sr[1][0];
    grid[1][2] = a_rd;
    grid[2][0] = sr[2][1];
    grid[2][1] = sr[2][0];
    grid[2][2] = pixel_in;
  end

  // Border fill: zero out-of-image taps, or clamp row first, then column.
  always_comb begin
    logic       row_ok;
    logic       col_ok;
    logic [1:0] rs;
    logic [1:0] cs;
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    window_d = '0;
    row_ok   = 1'b0;
    col_ok   = 1'b0;
    rs       = '0;
    cs       = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        row_ok = int'(ye) >= (2 - r);
        col_ok = int'(xe) >= (2 - c);
        rs     = row_ok ? 2'(r) : 2'(2 - int'(ye));
        cs     = col_ok ? 2'(c) : 2'(2 - int'(xe));
        if (BORDER_MODE == 0) begin
          window_d[(r*3+c)*DATA_W +: DATA_W] = (row_ok && col_ok) ? grid[r][c] : '0;
        end else begin
          window_d[(r*3+c)*DATA_W +: DATA_W] = grid[rs][cs];
        end
      end
    end
  end

  // Column and row position tracking; vsync clears before the pixel counts.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      if (vsync) begin
        x <= '0;
        y <= '0;
      end
      if (de) begin
        if (xe == XW'(WIDTH - 1)) begin
          x <= '0;
          y <= (ye == 2'd2) ? 2'd2 : ye + 2'd1;
        end else begin
          x <= xe + 1'b1;
        end
      end
    end
  end

  // Line RAMs and column shift registers advance only on accepted pixels.
  always_ff @(posedge clk) begin
    // NOTE: the line RAMs and shift registers are not reset; stale contents
    // are always masked by the border logic, and a reset port would block
    // mapping the RAMs onto memory primitives.
    if (de) begin
      ram_b[xe] <= a_rd;
      ram_a[xe] <= pixel_in;
      sr[0][1]  <= sr[0][0];
      sr[0][0]  <= b_rd;
      sr[1][1]  <= sr[1][0];
      sr[1][0]  <= a_rd;
      sr[2][1]  <= sr[2][0];
      sr[2][0]  <= pixel_in;
    end
  end

  // Registered outputs: window and flags one cycle after the accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      window       <= '0;
      out_valid    <= 1'b0;
      out_interior <= 1'b0;
      out_hsync    <= 1'b0;
      out_vsync    <= 1'b0;
    end else begin
      out_hsync <= hsync;
      out_vsync <= vsync;
      out_valid <= de;
      if (de) begin
        window       <= window_d;
        out_interior <= (int'(xe) >= 2) && (ye == 2'd2);
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 with WIDTH=10, DATA_W=8.
// Two instances share the stimulus: zero-pad and replicate border modes.
module tb_window_gen_3x3;

  localparam int DW = 8;
  localparam int W  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pixel_in;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [9*DW-1:0] window0, window1;
  logic          valid0, valid1, int0, int1;
  logic          hs0, hs1, vs0, vs1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  window_gen_3x3 #(.DATA_W(DW), .WIDTH(W), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .hsync(hsync), .vsync(vsync),
    .de(de), .window(window0), .out_valid(valid0), .out_interior(int0),
    .out_hsync(hs0), .out_vsync(vs0)
  );

  window_gen_3x3 #(.DATA_W(DW), .WIDTH(W), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .hsync(hsync), .vsync(vsync),
    .de(de), .window(window1), .out_valid(valid1), .out_interior(int1),
    .out_hsync(hs1), .out_vsync(vs1)
  );

  task automatic check(input string tag, input logic [9*DW-1:0] obs,
                       input logic [9*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packs taps p1..p9 with p1 in the least significant slot.
  function automatic logic [9*DW-1:0] win9(input int p1, input int p2, input int p3,
                                           input int p4, input int p5, input int p6,
                                           input int p7, input int p8, input int p9);
    return {DW'(p9), DW'(p8), DW'(p7), DW'(p6), DW'(p5), DW'(p4),
            DW'(p3), DW'(p2), DW'(p1)};
  endfunction

  // One clock cycle with the given inputs; outputs settle by return.
  task automatic cycle(input logic d, input logic vs, input int pix);
    de       = d;
    vsync    = vs;
    pixel_in = DW'(pix);
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int x, input int y);
    cycle(1'b1, 1'b0, 100 + x + 10 * y);
  endtask

  logic [9*DW-1:0] held;

  initial begin
    rst = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b1; pixel_in = 8'd77;
    #1;
    // Reset held 3 cycles with de=1.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 77);
      check("rst_window", window0, '0);
      check("rst_valid", valid0, 0);
      check("rst_interior", int0, 0);
      check("rst_vsync", vs0, 0);
    end
    rst = 1'b0;

    // Frame start, then row 0.
    cycle(1'b0, 1'b1, 0);
    check("vsync_out", vs0, 1);
    check("vsync_novalid", valid0, 0);
    px(0, 0);
    check("m0_p00_window", window0, win9(0,0,0,0,0,0,0,0,100));
    check("m0_p00_valid", valid0, 1);
    check("m0_p00_interior", int0, 0);
    check("m1_p00_window", window1, win9(100,100,100,100,100,100,100,100,100));
    for (int x = 1; x < W; x++) px(x, 0);

    // Row 1.
    px(0, 1);
    px(1, 1);
    check("m1_p11_window", window1, win9(100,100,101,100,100,101,110,110,111));
    check("m1_p11_interior", int1, 0);
    for (int x = 2; x < W; x++) px(x, 1);

    // Row 2 up to x=4, then a 3-cycle gap.
    for (int x = 0; x < 5; x++) px(x, 2);
    held = win9(102,103,104,112,113,114,122,123,124);
    check("m0_p42_window", window0, held);
    check("m0_p42_interior", int0, 1);
    hsync = 1'b1;
    cycle(1'b0, 1'b0, 0);
    check("gap0_valid", valid0, 0);
    check("gap0_window", window0, held);
    check("hsync_out", hs0, 1);
    hsync = 1'b0;
    cycle(1'b0, 1'b0, 0);
    check("gap1_valid", valid1, 0);
    check("gap1_window", window0, held);
    check("hsync_low", hs0, 0);
    cycle(1'b0, 1'b0, 0);
    check("gap2_valid", valid0, 0);
    check("gap2_window", window0, held);
    px(5, 2);
    check("m0_p52_window", window0, win9(103,104,105,113,114,115,123,124,125));
    check("m0_p52_interior", int0, 1);
    check("m0_p52_valid", valid0, 1);
    for (int x = 6; x < W; x++) px(x, 2);

    // Row 3 up to x=5 (y saturates at 2, rows still slide).
    for (int x = 0; x < 6; x++) px(x, 3);
    check("m0_p53_window", window0, win9(113,114,115,123,124,125,133,134,135));
    check("m0_p53_valid", valid0, 1);
    check("m0_p53_interior", int0, 1);
    check("m1_p53_window", window1, win9(113,114,115,123,124,125,133,134,135));

    // vsync with de at would-be (6,3): becomes (0,0) of a new frame.
    cycle(1'b1, 1'b1, 100);
    check("vs_de_m0_window", window0, win9(0,0,0,0,0,0,0,0,100));
    check("vs_de_vsync", vs0, 1);
    check("vs_de_interior", int0, 0);
    check("vs_de_m1_window", window1, win9(100,100,100,100,100,100,100,100,100));
    px(1, 0);
    check("new_p10_m0_window", window0, win9(0,0,0,0,0,0,0,100,101));

    // Reset mid-line: next pixel is (0,0) without vsync.
    rst = 1'b1;
    cycle(1'b1, 1'b0, 55);
    check("midrst_valid", valid0, 0);
    check("midrst_window", window0, '0);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 100);
    check("postrst_m0_window", window0, win9(0,0,0,0,0,0,0,0,100));
    check("postrst_interior", int0, 0);
    check("postrst_m1_window", window1, win9(100,100,100,100,100,100,100,100,100));
    cycle(1'b0, 1'b0, 0);
    check("end_valid", valid0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
